indirect_mem_unit: RTL
======================

# indirect_mem_unit

Parametrised memory-indirection engine between the pipeline MEM stage (P_ side) and the data memory/cache (D_ side). It accepts one request at a time, performs 0 to MAX_LEVELS pointer-fetch reads, then the final read or write at the resolved address. Requests are registered so both ports are fully decoupled. The unit serves LDI/STI and deeper indirect modes with a single registered datapath.

## Interface
Parameters:
- ADDR_W, 16, address width
- DATA_W, 16, data width (multiple of 8, at least ADDR_W)
- MAX_LEVELS, 2, maximum pointer-fetch levels per request (at least 1)

Ports (BE_W = DATA_W/8, LW = $clog2(MAX_LEVELS+1)):
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- P_mem_read  in  1  read request
- P_mem_write  in  1  write request (read has priority if both set)
- P_mem_address  in  ADDR_W  initial address
- P_mem_wdata  in  DATA_W  write data
- P_mem_byte_enable  in  BE_W  final-access byte mask
- P_levels  in  LW  pointer levels (0 = direct)
- P_mem_resp  out  1  one-cycle completion pulse
- P_mem_rdata  out  DATA_W  final read data, valid with P_mem_resp
- P_mem_error  out  1  one-cycle abort pulse (macro only)
- D_mem_read  out  1
- D_mem_write  out  1
- D_mem_address  out  ADDR_W
- D_mem_wdata  out  DATA_W
- D_mem_byte_enable  out  BE_W
- D_mem_rdata  in  DATA_W
- D_mem_resp  in  1
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, PTR, FINAL, RESP.
- IDLE: on P_mem_read or P_mem_write, capture the operation, address, wdata, byte enable, and levels into registers. Levels above MAX_LEVELS are clamped to MAX_LEVELS. The next state is PTR if levels > 0, otherwise FINAL.
- PTR: D_mem_read=1, D_mem_address=addr_q, D_mem_byte_enable all ones. On D_mem_resp, addr_q <= D_mem_rdata[ADDR_W-1:0] and cnt_q decrements. When cnt_q reaches 0, go to FINAL; otherwise stay in PTR, which issues the next fetch after a one-cycle deassertion.
- FINAL: D_mem_read or D_mem_write follows the captured operation. Address is addr_q, with the captured wdata and byte enable. On D_mem_resp, rdata_q <= D_mem_rdata and the state goes to RESP.
- RESP: P_mem_resp=1 and P_mem_rdata=rdata_q for exactly one cycle, then IDLE.
- Pointer LSB: cleared before use (word-aligned) when the macro is absent.
- P_mem_rdata holds its last value outside RESP. For writes it holds its previous value.
- D_ strobes are deasserted in the cycle after each D_mem_resp. D_mem_resp seen in IDLE or RESP is ignored.

## Timing
- Reset values: state IDLE; all D_ strobes 0; D_mem_address, D_mem_wdata, D_mem_byte_enable, P_mem_rdata 0; P_mem_resp, P_mem_error, busy 0.
- All outputs are registered or decoded from registered state only, with no combinational P-to-D path.
- Latency: with request seen in IDLE at cycle t, L levels, and memory responding k cycles after strobe assertion:
  - each access takes k cycles of strobe plus 1 turnaround cycle;
  - P_mem_resp rises at t + 1 + (L+1)(k+1) - 1;
  - for k=1: L=0 gives t+2, L=1 gives t+4.
- Handshake:
  - the requester holds its request stable until P_mem_resp;
  - it must deassert or change the request in the cycle after P_mem_resp;
  - IDLE accepts a new request in that cycle, so back-to-back requests have no extra bubble.
- Reset mid-operation: immediate return to IDLE, with strobes dropped asynchronously and no P_mem_resp. The downstream memory is reset in the same domain.
- Request deasserted by the requester while busy: the operation completes regardless, because it was captured.

## Configuration
- INDIRECT_ALIGN_CHECK_EN defined: a fetched pointer with bit 0 set aborts the request.
  - No further D_ access is made.
  - RESP asserts P_mem_error=1 instead of P_mem_resp for one cycle, then the state returns to IDLE.
  - The check applies only to pointers that feed a word access, i.e. when the final byte enable is all ones or the pointer feeds another level.
- Undefined: the pointer LSB is silently cleared and P_mem_error is tied to 0.

## Test plan
- Direct read with k=1: read, levels=0, address 0x0040, memory[0x0040]=0x1234. Required: P_mem_resp at t+2 with rdata 0x1234, and exactly one D read.
- LDI: levels=1, memory[0x0100]=0x0200, memory[0x0200]=0xBEEF. Required: D reads at 0x0100 then 0x0200, and P_mem_resp at t+4 with 0xBEEF.
- STI byte write: levels=1, write 0x00AB with byte enable 01, memory[0x0300]=0x0400. Required:
  - the pointer read uses byte enable 11;
  - the final write goes to 0x0400 with byte enable 01;
  - only the low byte of memory[0x0400] changes.
- Two levels with k=3 wait states, plus a clamp: levels=3 with MAX_LEVELS=2. Required: exactly 2 pointer reads plus the final access, and P_mem_resp at t+12.
- Reset during PTR: assert rst_n=0 on the cycle after the first D strobe. Required: strobes drop in the same cycle, no P_mem_resp, and a new request after reset completes normally.
- Odd pointer 0x0201, word read:
  - with the macro: P_mem_error pulse, no final access;
  - without the macro: final read at 0x0200 and P_mem_resp.

Source files
------------

// File: rtl/indirect_mem_unit.sv
// rtl/indirect_mem_unit.sv - memory-indirection engine: 0..MAX_LEVELS pointer fetches, then final access
// Optional INDIRECT_ALIGN_CHECK_EN: abort on an odd pointer that feeds a word access
module indirect_mem_unit #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int MAX_LEVELS = 2,
  localparam int BE_W      = DATA_W / 8,
  localparam int LW        = $clog2(MAX_LEVELS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              P_mem_read,
  input  logic              P_mem_write,
  input  logic [ADDR_W-1:0] P_mem_address,
  input  logic [DATA_W-1:0] P_mem_wdata,
  input  logic [BE_W-1:0]   P_mem_byte_enable,
  input  logic [LW-1:0]     P_levels,
  output logic              P_mem_resp,
  output logic [DATA_W-1:0] P_mem_rdata,
  output logic              P_mem_error,
  output logic              D_mem_read,
  output logic              D_mem_write,
  output logic [ADDR_W-1:0] D_mem_address,
  output logic [DATA_W-1:0] D_mem_wdata,
  output logic [BE_W-1:0]   D_mem_byte_enable,
  input  logic [DATA_W-1:0] D_mem_rdata,
  input  logic              D_mem_resp,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PTR   = 2'd1,
    S_FINAL = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_is_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [BE_W-1:0]   r_be;
  logic [LW-1:0]     r_cnt;
  logic [DATA_W-1:0] r_rdata;
  logic              r_d_read;
  logic              r_d_write;
  logic [BE_W-1:0]   r_d_be;
  logic              r_p_resp;
  logic              r_p_err;

  logic [LW-1:0]     w_levels;
  logic [ADDR_W-1:0] w_ptr;
  logic              w_ptr_bad;

  assign w_levels = (P_levels > LW'(MAX_LEVELS)) ? LW'(MAX_LEVELS) : P_levels;

`ifdef INDIRECT_ALIGN_CHECK_EN
  // Odd pointers are only illegal when they address a full word
  logic w_word_access;
  assign w_word_access = (r_cnt > LW'(1)) || (r_be == '1);
  assign w_ptr         = D_mem_rdata[ADDR_W-1:0];
  assign w_ptr_bad     = w_ptr[0] && w_word_access;
`else
  assign w_ptr     = D_mem_rdata[ADDR_W-1:0] & ~ADDR_W'(1);
  assign w_ptr_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_is_write <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_cnt      <= '0;
      r_rdata    <= '0;
      r_d_read   <= 1'b0;
      r_d_write  <= 1'b0;
      r_d_be     <= '0;
      r_p_resp   <= 1'b0;
      r_p_err    <= 1'b0;
    end else begin
      r_p_resp <= 1'b0;
      r_p_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (P_mem_read || P_mem_write) begin
            r_is_write <= !P_mem_read;
            r_addr     <= P_mem_address;
            r_wdata    <= P_mem_wdata;
            r_be       <= P_mem_byte_enable;
            r_cnt      <= w_levels;
            if (w_levels != '0) begin
              r_state  <= S_PTR;
              r_d_read <= 1'b1;
              r_d_be   <= '1;
            end else begin
              r_state   <= S_FINAL;
              r_d_read  <= P_mem_read;
              r_d_write <= !P_mem_read;
              r_d_be    <= P_mem_byte_enable;
            end
          end
        end
        S_PTR: begin
          if (r_d_read) begin
            if (D_mem_resp) begin
              r_d_read <= 1'b0;
              if (w_ptr_bad) begin
                r_state <= S_RESP;
                r_p_err <= 1'b1;
              end else begin
                r_addr <= w_ptr;
                r_cnt  <= r_cnt - 1'b1;
                if (r_cnt == LW'(1)) r_state <= S_FINAL;
              end
            end
          end else begin
            // strobe low here is the turnaround cycle; issue the next fetch
            r_d_read <= 1'b1;
          end
        end
        S_FINAL: begin
          if (r_d_read || r_d_write) begin
            if (D_mem_resp) begin
              r_d_read  <= 1'b0;
              r_d_write <= 1'b0;
              if (!r_is_write) r_rdata <= D_mem_rdata;
              r_state  <= S_RESP;
              r_p_resp <= 1'b1;
            end
          end else begin
            r_d_read  <= !r_is_write;
            r_d_write <= r_is_write;
            r_d_be    <= r_be;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign P_mem_resp        = r_p_resp;
  assign P_mem_error       = r_p_err;
  assign P_mem_rdata       = r_rdata;
  assign D_mem_read        = r_d_read;
  assign D_mem_write       = r_d_write;
  assign D_mem_address     = r_addr;
  assign D_mem_wdata       = r_wdata;
  assign D_mem_byte_enable = r_d_be;
  assign busy              = (r_state != S_IDLE);

endmodule
